// File: rtl/mips32_mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: port indices, FSM states,
// default widths and the cyclic round-robin index helper.
package mips32_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   localparam logic [1:0] PORT_IF = 2'd0;
   localparam logic [1:0] PORT_DM = 2'd1;
   localparam logic [1:0] PORT_LD = 2'd2;

   typedef enum logic [1:0] {ARB, LOCKED, BACKOFF} arb_state_t;

   // Port k steps after p in the cyclic order IF -> DM -> LD.
   function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
      int s;
      s = (int'(p) + k) % 3;
      return s[1:0];
   endfunction

endpackage

// File: rtl/mips32_rr_pick.sv
// 3-way round-robin selector: priority starts at the port after ptr and the
// result is a one-hot grant among the unmasked requesters.
module mips32_rr_pick
   import mips32_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   input  logic [2:0] mask,
   output logic [2:0] gnt
);

   logic [2:0] eff;
   assign eff = req & mask;

   // Scan lowest priority first so the highest-priority hit is written last.
   always_comb begin
      gnt = '0;
      for (int k = 3; k >= 1; k--) begin
         if (eff[rr_idx(ptr, k)]) begin
            gnt = '0;
            gnt[rr_idx(ptr, k)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Round-robin arbiter for the shared instruction/data memory with loader lock,
// lock timeout and backoff. Define MIPS32_ARB_STATS_EN for per-port grant counters.
module mips32_mem_arbiter
   import mips32_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int LOCK_MAX = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic              ld_lock,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] rd_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef MIPS32_ARB_STATS_EN
   input  logic              stat_clr,
   output logic [15:0]       stat_if,
   output logic [15:0]       stat_dm,
   output logic [15:0]       stat_ld,
`endif
   output logic              lock_err
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   arb_state_t       state;
   logic [1:0]       rr_ptr;
   logic [CNT_W-1:0] lock_cnt;
   logic [2:0]       req, mask, gnt;

   assign req = {ld_req, dm_req, if_req};

   // Grants are forced off while reset is asserted, not just after it.
   always_comb begin
      mask = 3'b111;
      if (!rst_n)              mask = 3'b000;
      else if (state == LOCKED) mask = 3'b100;
   end

   mips32_rr_pick u_pick (
      .req  (req),
      .ptr  (rr_ptr),
      .mask (mask),
      .gnt  (gnt)
   );

   assign if_gnt   = gnt[PORT_IF];
   assign dm_gnt   = gnt[PORT_DM];
   assign ld_gnt   = gnt[PORT_LD];
   assign mem_en   = |gnt;
   assign rd_data  = mem_rdata;
   assign lock_err = (state == LOCKED) && ld_lock && (lock_cnt == CNT_W'(LOCK_MAX));

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = if_addr;
      mem_wdata = '0;
      if (gnt[PORT_DM]) begin
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (gnt[PORT_LD]) begin
         mem_we    = ld_we;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB;
         rr_ptr    <= PORT_IF;
         lock_cnt  <= '0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         ld_rvalid <= 1'b0;
      end else begin
         if_rvalid <= gnt[PORT_IF];
         dm_rvalid <= gnt[PORT_DM] & ~dm_we;
         ld_rvalid <= gnt[PORT_LD] & ~ld_we;

         if (gnt[PORT_IF])      rr_ptr <= PORT_IF;
         else if (gnt[PORT_DM]) rr_ptr <= PORT_DM;
         else if (gnt[PORT_LD]) rr_ptr <= PORT_LD;

         case (state)
            ARB: begin
               if (gnt[PORT_LD] && ld_lock) begin
                  state    <= LOCKED;
                  lock_cnt <= CNT_W'(1);
               end
            end
            LOCKED: begin
               if (!ld_lock) begin
                  state    <= ARB;
                  rr_ptr   <= PORT_LD;
                  lock_cnt <= '0;
               end else if (lock_cnt == CNT_W'(LOCK_MAX)) begin
                  state    <= BACKOFF;
                  lock_cnt <= '0;
               end else begin
                  lock_cnt <= lock_cnt + CNT_W'(1);
               end
            end
            BACKOFF: begin
               if (!ld_lock) state <= ARB;
            end
            default: state <= ARB;
         endcase
      end
   end

`ifdef MIPS32_ARB_STATS_EN
   logic [2:0][15:0] stat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else begin
         for (int p = 0; p < 3; p++) begin
            if (stat_clr)
               stat_q[p] <= '0;
            else if (gnt[p] && stat_q[p] != 16'hFFFF)
               stat_q[p] <= stat_q[p] + 16'd1;
         end
      end
   end

   assign stat_if = stat_q[PORT_IF];
   assign stat_dm = stat_q[PORT_DM];
   assign stat_ld = stat_q[PORT_LD];
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter with a behavioural 1024x32 sync-read memory.
// Covers the MIPS32_ARB_STATS_EN counters when that macro is defined.
module tb_mips32_mem_arbiter;
   import mips32_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          if_req, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic          dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
   logic          mem_en, mem_we, lock_err;
   logic [AW-1:0] mem_addr;
`ifdef MIPS32_ARB_STATS_EN
   logic          stat_clr;
   logic [15:0]   stat_if, stat_dm, stat_ld;
`endif

   always #5 clk = ~clk;

   mips32_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
      .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
      .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
      .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MIPS32_ARB_STATS_EN
      .stat_clr(stat_clr), .stat_if(stat_if), .stat_dm(stat_dm), .stat_ld(stat_ld),
`endif
      .lock_err(lock_err)
   );

   logic [DW-1:0] mem [1024];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   logic [2:0] g, rv;
   assign g  = {ld_gnt, dm_gnt, if_gnt};
   assign rv = {ld_rvalid, dm_rvalid, if_rvalid};

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] init_word(input int a);
      return 32'hA500_0000 | 32'(a);
   endfunction

   // Addresses used by the round-robin read test: IF=1, DM=2, LD=3.
   function automatic int addr_of(input logic [2:0] onehot);
      case (onehot)
         3'b001:  return 1;
         3'b010:  return 2;
         default: return 3;
      endcase
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] ord [6];
      int err_cnt, err_at, blocked, bif, bdm, bld;
      ord = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

      for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
      mem_rdata = '0;
      if_req = 1'b1; if_addr = '0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0; ld_addr = '0; ld_wdata = '0;
`ifdef MIPS32_ARB_STATS_EN
      stat_clr = 1'b0;
`endif

      // Reset: outputs quiet even with requests present.
      #1 rst_n = 1'b0;
      #13;
      check("rst_gnt", 32'(g), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_rvalid", 32'(rv), 32'd0);
      check("rst_lock_err", 32'(lock_err), 32'd0);
`ifdef MIPS32_ARB_STATS_EN
      check("rst_stat_if", 32'(stat_if), 32'd0);
`endif
      if_req = 1'b0; dm_req = 1'b0;
      step();
      rst_n = 1'b1;

      // Read in flight discarded by reset.
      if_req = 1'b1; if_addr = 10'd5;
      #4 check("inflight_gnt", 32'(g), 32'b001);
      step();
      if_req = 1'b0;
      rst_n = 1'b0;
      #1 check("inflight_rv_rst", 32'(if_rvalid), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      #4 check("inflight_rv_post", 32'(rv), 32'd0);
      step();

      // All three reading: rotation from rr_ptr=IF is DM, LD, IF, ...
      if_req = 1'b1; if_addr = 10'd1;
      dm_req = 1'b1; dm_addr = 10'd2;
      ld_req = 1'b1; ld_addr = 10'd3;
      for (int k = 0; k < 6; k++) begin
         #4;
         check("rr_gnt", 32'(g), 32'(ord[k]));
         if (k > 0) begin
            check("rr_rvalid", 32'(rv), 32'(ord[k-1]));
            check("rr_rdata", rd_data, init_word(addr_of(ord[k-1])));
         end
         step();
      end
      if_req = 1'b0; dm_req = 1'b0; ld_req = 1'b0;
      #4;
      check("rr_rvalid_last", 32'(rv), 32'b001);
      check("rr_rdata_last", rd_data, init_word(1));
      step();

      // DM store then load of 3F0.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3F0; dm_wdata = 32'hDEADBEEF;
      #4;
      check("st_gnt", 32'(dm_gnt), 32'd1);
      check("st_mem_we", 32'(mem_we), 32'd1);
      check("st_mem_addr", 32'(mem_addr), 32'h3F0);
      check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
      step();
      dm_we = 1'b0;
      #4;
      check("st_no_rvalid", 32'(dm_rvalid), 32'd0);
      check("ld_gnt_dm", 32'(dm_gnt), 32'd1);
      step();
      dm_req = 1'b0;
      #4;
      check("ld_rvalid_dm", 32'(dm_rvalid), 32'd1);
      check("ld_rdata_dm", rd_data, 32'hDEADBEEF);
      step();

      // Loader locks for 5 writes while IF waits.
      if_req = 1'b1; if_addr = '0;
      ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ld_addr = 10'h100 + 10'(k);
         ld_wdata = 32'h1000 + 32'(k);
         #4;
         check("lock_if_gnt", 32'(if_gnt), 32'd0);
         check("lock_ld_gnt", 32'(ld_gnt), 32'd1);
         step();
      end
      ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0;
      #4 check("unlock_cycle_if_gnt", 32'(if_gnt), 32'd0);
      step();
      #4 check("post_unlock_if_gnt", 32'(if_gnt), 32'd1);
      step();
      if_req = 1'b0;

      // Lock held 70 cycles: timeout at the 64th locked cycle, then backoff.
      err_cnt = 0; err_at = -1; blocked = 0; bif = 0; bdm = 0; bld = 0;
      ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1; ld_addr = 10'h200;
      dm_we = 1'b0; dm_addr = 10'd7; if_addr = 10'd8;
      for (int k = 0; k < 70; k++) begin
         #4;
         if (lock_err) begin err_cnt++; err_at = k; end
         if (k >= 1 && k <= 64) blocked += int'(if_gnt) + int'(dm_gnt);
         if (k >= 65) begin
            bif += int'(if_gnt); bdm += int'(dm_gnt); bld += int'(ld_gnt);
         end
         step();
         if_req = 1'b1; dm_req = 1'b1;
      end
      check("lock_err_count", 32'(err_cnt), 32'd1);
      check("lock_err_cycle", 32'(err_at), 32'd64);
      check("lock_blocked", 32'(blocked), 32'd0);
      check("backoff_if", 32'(bif), 32'd2);
      check("backoff_dm", 32'(bdm), 32'd2);
      check("backoff_ld", 32'(bld), 32'd1);
      ld_lock = 1'b0;
      #4 check("backoff_exit_ld", 32'(ld_gnt), 32'd1);
      step();
      if_req = 1'b0; dm_req = 1'b0; ld_lock = 1'b1;
      #4 check("relock_ld_gnt", 32'(ld_gnt), 32'd1);
      step();
      if_req = 1'b1;
      #4;
      check("relock_if_gnt", 32'(if_gnt), 32'd0);
      check("relock_ld_gnt2", 32'(ld_gnt), 32'd1);
      step();
      if_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0;
      step(); step();

`ifdef MIPS32_ARB_STATS_EN
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      #4 check("stat_clear", 32'(stat_if), 32'd0);
      step();
      if_req = 1'b1;
      repeat (10) step();
      stat_clr = 1'b1;
      #4 check("stat_if_10", 32'(stat_if), 32'd10);
      step();
      stat_clr = 1'b0; if_req = 1'b0;
      #4 check("stat_if_clr", 32'(stat_if), 32'd0);
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
